sha2_padder: RTL and testbench

SHA2_PADDER -- requirements
Module: sha2_padder

---
 rtl/sha2_padder.sv | 190 +++++++++++++++++++
 tb/tb_sha2_padder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_padder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sha2_padder: packs message words into SHA-224/256/384/512 padded blocks.  |
// | Optional macro SHA2_PADDER_BYTE_STRB_EN enables partial final words.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module sha2_padder #(
  parameter int DataWidth  = 64,
  parameter int BlockWidth = 512,
  parameter int DataBytes  = DataWidth >> 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [DataWidth-1:0]  data_i,
  input  logic [DataBytes-1:0]  strb_i,
  input  logic                  last_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [BlockWidth-1:0] block_o,
  output logic                  block_valid_o,
  input  logic                  block_ready_i,
  output logic                  block_first_o,
  output logic                  block_last_o,
  output logic                  error_o
);
  localparam int BlockBytes = BlockWidth / 8;
  localparam int LenBytes   = BlockWidth / 64;
  localparam int PtrW       = $clog2(BlockBytes);

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    EMIT       = 2'd1,
    EXTRA      = 2'd2,
    EMIT_FINAL = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [63:0]           len_q, len_d;
  logic [BlockWidth-1:0] block_q, block_d;
  logic                  first_q, first_d;
  logic                  pend_q, pend_d;
  logic                  pad80_q, pad80_d;
  logic                  err_q, err_d;

  int   n_valid;
  logic strb_bad;

`ifdef SHA2_PADDER_BYTE_STRB_EN
  // A legal tail strobe is a run of ones starting at the MSB lane.
  always_comb begin
    logic seen_gap;
    n_valid  = 0;
    strb_bad = 1'b0;
    seen_gap = 1'b0;
    for (int i = DataBytes - 1; i >= 0; i--) begin
      if (strb_i[i]) begin
        n_valid = n_valid + 1;
        if (seen_gap) strb_bad = 1'b1;
      end else begin
        seen_gap = 1'b1;
      end
    end
  end
`else
  logic unused_strb;
  assign unused_strb = ^strb_i;
  assign n_valid     = DataBytes;
  assign strb_bad    = 1'b0;
`endif

  always_comb begin
    int   p;
    int   nb;
    logic abort;
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    block_d = block_q;
    first_d = first_q;
    pend_d  = pend_q;
    pad80_d = pad80_q;
    err_d   = 1'b0;
    abort   = 1'b0;
    p       = int'(ptr_q);
    nb      = last_i ? n_valid : DataBytes;

    case (state_q)
      FILL: begin
        if (valid_i) begin
          if (last_i && strb_bad) begin
            abort = 1'b1;
          end else begin
            for (int b = 0; b < BlockBytes; b++) begin
              if (b >= p && b < p + nb)
                block_d[BlockWidth-1-8*b -: 8] = data_i[DataWidth-1-8*(b-p) -: 8];
              else if (last_i && b == p + nb)
                block_d[BlockWidth-1-8*b -: 8] = 8'h80;
              else if (last_i && b > p + nb)
                block_d[BlockWidth-1-8*b -: 8] = 8'h00;
            end
            len_d = len_q + 64'(nb * 8);
            if (!last_i) begin
              ptr_d = PtrW'(p + DataBytes);
              if (p + DataBytes == BlockBytes) begin
                state_d = EMIT;
                pend_d  = 1'b0;
              end
            end else begin
              ptr_d = '0;
              if (p + nb <= BlockBytes - LenBytes - 1) begin
                // Upper length bytes of wide blocks were already zero-padded.
                block_d[63:0] = len_d;
                state_d       = EMIT_FINAL;
              end else begin
                state_d = EMIT;
                pend_d  = 1'b1;
                pad80_d = (p + nb == BlockBytes);
              end
            end
          end
        end
      end
      EMIT: begin
        if (block_ready_i) begin
          first_d = 1'b0;
          state_d = pend_q ? EXTRA : FILL;
        end
      end
      EXTRA: begin
        block_d                        = '0;
        block_d[BlockWidth-1 -: 8]     = pad80_q ? 8'h80 : 8'h00;
        block_d[63:0]                  = len_q;
        pend_d                         = 1'b0;
        pad80_d                        = 1'b0;
        state_d                        = EMIT_FINAL;
      end
      EMIT_FINAL: begin
        if (block_ready_i) begin
          state_d = FILL;
          ptr_d   = '0;
          len_d   = '0;
          first_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase

    if (clear_i || abort) begin
      state_d = FILL;
      ptr_d   = '0;
      len_d   = '0;
      first_d = 1'b1;
      pend_d  = 1'b0;
      pad80_d = 1'b0;
      err_d   = abort && !clear_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
      ptr_q   <= '0;
      len_q   <= '0;
      block_q <= '0;
      first_q <= 1'b1;
      pend_q  <= 1'b0;
      pad80_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      block_q <= block_d;
      first_q <= first_d;
      pend_q  <= pend_d;
      pad80_q <= pad80_d;
      err_q   <= err_d;
    end
  end

  assign ready_o       = (state_q == FILL);
  assign block_valid_o = (state_q == EMIT) || (state_q == EMIT_FINAL);
  assign block_last_o  = (state_q == EMIT_FINAL);
  assign block_first_o = first_q;
  assign block_o       = block_q;
  assign error_o       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_sha2_padder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sha2_padder: scoreboard bench for sha2_padder (64-bit words, 512 blk). |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_sha2_padder;
  logic         clk_i = 1'b0;
  logic         rst_ni, clear_i, last_i, valid_i, ready_o;
  logic [63:0]  data_i;
  logic [7:0]   strb_i;
  logic [511:0] block_o;
  logic         block_valid_o, block_ready_i, block_first_o, block_last_o, error_o;

  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  bit           bp_hold = 1'b0;
  bit           bp_rand = 1'b0;
  logic [511:0] last_blk = '0;
  logic [511:0] prev_blk = '0;
  bit           stall_prev = 1'b0;

  sha2_padder #(.DataWidth(64), .BlockWidth(512)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .data_i(data_i), .strb_i(strb_i), .last_i(last_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .block_o(block_o), .block_valid_o(block_valid_o), .block_ready_i(block_ready_i),
    .block_first_o(block_first_o), .block_last_o(block_last_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference SHA-2 padding of a whole message, split into 64-byte blocks.
  task automatic push_expected(input byte unsigned m[$]);
    byte unsigned p[$];
    exp_t         e;
    logic [63:0]  bits;
    int           nblk;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < 64; k++) e.blk[511-8*k -: 8] = p[b*64+k];
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_word(input logic [63:0] d, input logic [7:0] s, input logic l);
    int cyc = 0;
    valid_i = 1'b1; data_i = d; strb_i = s; last_i = l;
    while (!ready_o && cyc < 300) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    if (cyc >= 300) check("in_ready_timeout", {511'd0, ready_o}, 512'd1);
    @(posedge clk_i); #1;
    valid_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic send_msg(input int len, input int pat, input bit expect_out);
    byte unsigned m[$];
    logic [63:0]  d;
    logic [7:0]   s;
    int           nw;
    for (int i = 0; i < len; i++)
      m.push_back(pat == 0 ? 8'h61 : pat == 1 ? 8'(i) : pat == 3 ? 8'(8'h61 + i) : 8'($urandom));
    if (expect_out) push_expected(m);
    nw = (len == 0) ? 1 : (len + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      for (int j = 0; j < 8; j++) begin
        if (w*8 + j < len) begin
          d[63-8*j -: 8] = m[w*8+j];
          s[7-j]         = 1'b1;
        end else begin
          d[63-8*j -: 8] = 8'($urandom);
          s[7-j]         = 1'b0;
        end
      end
      drive_word(d, s, w == nw - 1);
    end
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 600) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("drain", 512'(exp_q.size()), 512'd0);
  endtask

  initial begin
    block_ready_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      block_ready_i = bp_hold ? 1'b0 : (bp_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_ni) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && block_valid_o) check("hold_block", block_o, prev_blk);
      if (block_valid_o && block_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_block", block_o, 512'd0);
        end else begin
          e = exp_q.pop_front();
          check("block", block_o, e.blk);
          check("first", {511'd0, block_first_o}, {511'd0, e.first});
          check("last",  {511'd0, block_last_o},  {511'd0, e.last});
        end
        last_blk = block_o;
      end
      stall_prev = block_valid_o && !block_ready_i;
      prev_blk   = block_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] held;
    int           cyc;
    rst_ni = 1'b0; clear_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
    data_i = '0; strb_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", {511'd0, ready_o}, 512'd1);
    check("rst_valid", {511'd0, block_valid_o}, 512'd0);
    check("rst_first", {511'd0, block_first_o}, 512'd1);
    check("rst_last",  {511'd0, block_last_o}, 512'd0);
    check("rst_err",   {511'd0, error_o}, 512'd0);
    check("rst_block", block_o, 512'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

`ifdef SHA2_PADDER_BYTE_STRB_EN
    send_msg(3, 3, 1);
    wait_drain();
    check("abc_block", last_blk, {32'h61626380, 416'd0, 64'h18});
`else
    send_msg(8, 3, 1);
    wait_drain();
`endif
    send_msg(56, 0, 1);
    wait_drain();
    send_msg(64, 1, 1);
    wait_drain();

    // Output stall: data block held, input side blocked.
    bp_hold = 1'b1;
    send_msg(64, 2, 1);
    cyc = 0;
    while (!block_valid_o && cyc < 50) begin @(posedge clk_i); #1; cyc++; end
    valid_i = 1'b1; data_i = 64'hDEAD_BEEF_0BAD_F00D; strb_i = 8'hFF; last_i = 1'b0;
    @(negedge clk_i);
    held = block_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("stall_ready", {511'd0, ready_o}, 512'd0);
      check("stall_block", block_o, held);
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    bp_hold = 1'b0;
    wait_drain();

    bp_rand = 1'b1;
    send_msg(16, 2, 1);
    send_msg(120, 2, 1);
    send_msg(128, 1, 1);
    send_msg(40, 2, 1);
`ifdef SHA2_PADDER_BYTE_STRB_EN
    send_msg(0, 2, 1);
    send_msg(55, 2, 1);
    send_msg(57, 2, 1);
    send_msg(63, 2, 1);
    send_msg(1, 2, 1);
    send_msg(9, 2, 1);
`endif
    wait_drain();
    bp_rand = 1'b0;

    // Abort on word 3 of 8 via clear_i.
    drive_word(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
    drive_word(64'h2222_2222_2222_2222, 8'hFF, 1'b0);
    valid_i = 1'b1; data_i = 64'h3333_3333_3333_3333; strb_i = 8'hFF; clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0; valid_i = 1'b0;
    check("clear_valid", {511'd0, block_valid_o}, 512'd0);
    check("clear_ready", {511'd0, ready_o}, 512'd1);
`ifdef SHA2_PADDER_BYTE_STRB_EN
    send_msg(3, 3, 1);
    wait_drain();
    check("abc_after_clear", last_blk, {32'h61626380, 416'd0, 64'h18});
    drive_word(64'h6100_6200_0000_0000, 8'hA0, 1'b1);
    check("err_pulse", {511'd0, error_o}, 512'd1);
    @(posedge clk_i); #1;
    check("err_clear", {511'd0, error_o}, 512'd0);
`else
    send_msg(8, 3, 1);
    wait_drain();
    begin
      byte unsigned m[$];
      m = '{8'h61, 8'h00, 8'h62, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      push_expected(m);
    end
    drive_word(64'h6100_6200_0000_0000, 8'hA0, 1'b1);
    check("err_tied", {511'd0, error_o}, 512'd0);
`endif
    wait_drain();

    // Reset in the middle of a message.
    send_msg(24, 2, 0);
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    check("rst_mid_valid", {511'd0, block_valid_o}, 512'd0);
    check("rst_mid_ready", {511'd0, ready_o}, 512'd1);
    send_msg(16, 2, 1);
    wait_drain();
    repeat (5) @(posedge clk_i);
    #1;
    check("final_idle", {511'd0, ready_o}, 512'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
